// File: rtl/scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// scoreboard_pkg
//   Shared constants and helpers for the register scoreboard.
//   REG_ADDR_W : width of a register index (x0..x31).
//   NUM_REGS   : number of architectural registers.
//   cnt_width  : bits needed to hold a pending count of 0..max_pending.
// ---------------------------------------------------------------------------
package scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   function automatic int cnt_width(input int max_pending);
      int w;
      w = 1;
      while ((1 << w) <= max_pending) w++;
      return w;
   endfunction

endpackage

// File: rtl/sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
//   Pending-write counter for one register: counts up on issue, down on
//   writeback, saturates at MAX_PENDING and never wraps below zero.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clr        : clear count (pipeline flush)
//     inc        : accepted issue writing this register
//     dec        : writeback retiring a write to this register
//     count      : current pending count
//     underflow  : writeback seen while count is zero (combinational)
// ---------------------------------------------------------------------------
module sb_counter #(
   parameter int MAX_PENDING = 3,
   parameter int CW          = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          underflow
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_PENDING);

   // A writeback with nothing pending is an error even if an issue to the
   // same register lands in the same cycle.
   assign underflow = dec && (count == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else begin
         unique case ({inc, dec})
            2'b10:   if (count < MAX_C) count <= count + 1'b1;
            2'b01:   if (count != '0)   count <= count - 1'b1;
            default: count <= count;  // idle, or issue and retire cancel out
         endcase
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Tracks in-flight register writes and blocks issue of instructions whose
//   sources are still pending or whose destination has too many writes
//   outstanding. x0 is never tracked.
//   Ports:
//     clk, rst                        : clock, synchronous active-high reset
//     issue_valid / issue_ready       : issue handshake from decode
//     issue_rs1/2, issue_rs1/2_used   : source indices and read enables
//     issue_rd_we, issue_rd           : destination write enable and index
//     wb_valid, wb_rd                 : writeback retiring one write
//     flush                           : discard all in-flight tracking
//     busy_mask                       : per-register pending flags (bit 0 = 0)
//     stall                           : issue_valid && !issue_ready
//     wb_err                          : sticky writeback-underflow flag
//   Build option:
//     SCOREBOARD_BYPASS_EN - a source whose single pending write retires in
//     the current cycle does not stall; the datapath must forward the
//     writeback data to that instruction.
// ---------------------------------------------------------------------------
module reg_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int MAX_PENDING = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [REG_ADDR_W-1:0] issue_rs1,
   input  logic [REG_ADDR_W-1:0] issue_rs2,
   input  logic                  issue_rs1_used,
   input  logic                  issue_rs2_used,
   input  logic                  issue_rd_we,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  flush,
   output logic [NUM_REGS-1:0]   busy_mask,
   output logic                  stall,
   output logic                  wb_err
);

   localparam int              CW    = cnt_width(MAX_PENDING);
   localparam logic [CW-1:0]   MAX_C = CW'(MAX_PENDING);
   localparam logic [CW-1:0]   ONE_C = CW'(1);

   logic [CW-1:0]       cnt [NUM_REGS];
   logic [NUM_REGS-1:0] underflow;
   logic                haz1, haz2, byp1, byp2, rd_full, accept;

   assign cnt[0]       = '0;
   assign underflow[0] = 1'b0;

`ifdef SCOREBOARD_BYPASS_EN
   // Last pending write retiring now: the source can take forwarded data.
   assign byp1 = wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == ONE_C);
   assign byp2 = wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == ONE_C);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign haz1    = issue_rs1_used && (issue_rs1 != '0) && (cnt[issue_rs1] != '0) && !byp1;
   assign haz2    = issue_rs2_used && (issue_rs2 != '0) && (cnt[issue_rs2] != '0) && !byp2;
   assign rd_full = issue_rd_we && (issue_rd != '0) && (cnt[issue_rd] >= MAX_C);

   assign issue_ready = !haz1 && !haz2 && !rd_full && !flush;
   assign stall       = issue_valid && !issue_ready;
   assign accept      = issue_valid && issue_ready;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(
         .MAX_PENDING (MAX_PENDING),
         .CW          (CW)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .clr       (flush),
         .inc       (accept && issue_rd_we && (issue_rd == REG_ADDR_W'(i))),
         .dec       (!flush && wb_valid && (wb_rd == REG_ADDR_W'(i))),
         .count     (cnt[i]),
         .underflow (underflow[i])
      );
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 1; i < NUM_REGS; i++) busy_mask[i] = (cnt[i] != '0);
   end

   // Sticky; a flush leaves it alone, only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)             wb_err <= 1'b0;
      else if (|underflow) wb_err <= 1'b1;
   end

endmodule
